// File: rtl/ula_pkg.sv
// ula_pkg: shared types, constants and condition evaluation for the ALU writeback stage
package ula_pkg;
  localparam int BITS = 16;
  localparam int RADDR = 4;
  localparam logic [1:0] FMT_ARLO = 2'b10;
  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_MI = 3'd3;
  localparam logic [2:0] COND_PL = 3'd4;
  localparam logic [2:0] COND_CS = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;
  typedef struct packed {
    logic [BITS-1:0]  resu;
    logic             o;
    logic             c;
    logic             s;
    logic             z;
    logic             we;
    logic [RADDR-1:0] dest;
    logic             upd;
  } wb_entry_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} wb_state_t;
  function automatic logic cond_eval(input logic [2:0] sel, input logic o, input logic c,
                                     input logic s, input logic z);
    return sel == COND_AL ? 1'b1 :
           sel == COND_EQ ? z :
           sel == COND_NE ? !z :
           sel == COND_MI ? s :
           sel == COND_PL ? !s :
           sel == COND_CS ? c :
           sel == COND_VS ? o : 1'b0;
  endfunction
endpackage

// File: rtl/ula_wb_fifo.sv
// ula_wb_fifo: in-order FIFO of writeback entries with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ula_wb_fifo #(
  parameter type T = ula_pkg::wb_entry_t,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  T              i_din,
  output T              o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_dout = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/ula_wb_stage.sv
// ula_wb_stage: buffers ALU results, retires them to the register file,
// holds the architectural flags and evaluates branch conditions on them.
module ula_wb_stage
  import ula_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_resu,
  input  logic             in_o,
  input  logic             in_c,
  input  logic             in_s,
  input  logic             in_z,
  input  logic [7:0]       in_op,
  input  logic             in_we,
  input  logic [RADDR-1:0] in_dest,
  output logic             rf_valid,
  input  logic             rf_ready,
  output logic             rf_we,
  output logic [RADDR-1:0] rf_waddr,
  output logic [BITS-1:0]  rf_wdata,
  output logic             flag_o,
  output logic             flag_c,
  output logic             flag_s,
  output logic             flag_z,
  output logic             flags_pending,
  input  logic [2:0]       cond_sel,
  output logic             cond_true,
  output logic [15:0]      retired
);
  localparam int CW = $clog2(DEPTH + 1);
  wb_state_t r_state, w_state_nx;
  wb_entry_t w_in, w_head;
  logic [CW-1:0] w_count, r_pend;
  logic w_full, w_empty, w_push, w_pop, w_unused_op;
  logic [15:0] r_retired;
  logic r_o, r_c, r_s, r_z;
  assign w_unused_op = ^in_op[5:0];
  assign in_ready = r_state != ST_FULL;
  assign rf_valid = r_state != ST_EMPTY;
  assign w_push = in_valid && in_ready;
  assign w_pop = rf_valid && rf_ready;
  assign w_in = '{resu: in_resu, o: in_o, c: in_c, s: in_s, z: in_z, we: in_we,
                  dest: in_dest, upd: in_op[7:6] == FMT_ARLO};
  ula_wb_fifo #(.T(wb_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_in),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign rf_we = rf_valid && w_head.we;
  assign rf_waddr = w_head.dest;
  assign rf_wdata = w_head.resu;
  assign {flag_o, flag_c, flag_s, flag_z} = {r_o, r_c, r_s, r_z};
  assign flags_pending = r_pend != '0;
  assign cond_true = cond_eval(cond_sel, r_o, r_c, r_s, r_z);
  assign retired = r_retired;
  always_comb begin
    w_state_nx = r_state;
    if (w_push && !w_pop) w_state_nx = w_count == CW'(DEPTH - 1) ? ST_FULL : ST_PARTIAL;
    else if (w_pop && !w_push) w_state_nx = w_count == CW'(1) ? ST_EMPTY : ST_PARTIAL;
  end
  // r_pend counts buffered flag-updating entries, so flags_pending needs no scan of the FIFO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_EMPTY;
      r_pend <= '0;
      r_retired <= '0;
      {r_o, r_c, r_s, r_z} <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pend <= r_pend + CW'(w_push && w_in.upd) - CW'(w_pop && w_head.upd);
      r_retired <= r_retired + 16'(w_pop);
      if (w_pop && w_head.upd) {r_o, r_c, r_s, r_z} <= {w_head.o, w_head.c, w_head.s, w_head.z};
    end
  always_ff @(posedge clk)
    if (!rst)
      assert ((r_state == ST_EMPTY) == w_empty && (r_state == ST_FULL) == w_full &&
              !(w_push && w_full) && !(w_pop && w_empty));
endmodule

// File: tb/tb_ula_wb_stage.sv
// tb_ula_wb_stage: directed and randomized checks of ula_wb_stage against a queue-based model
module tb_ula_wb_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_o = 0, in_c = 0, in_s = 0, in_z = 0, in_we = 0;
  logic [15:0] in_resu = 0;
  logic [7:0] in_op = 0;
  logic [3:0] in_dest = 0;
  logic rf_valid, rf_ready = 0, rf_we;
  logic [3:0] rf_waddr;
  logic [15:0] rf_wdata, retired;
  logic flag_o, flag_c, flag_s, flag_z, flags_pending, cond_true;
  logic [2:0] cond_sel = 0;
  int checks = 0, failures = 0;
  typedef struct {
    logic [15:0] resu;
    logic o, c, s, z, we;
    logic [3:0] dest;
    logic upd;
  } ent_t;
  ent_t q[$];
  logic [3:0] mf = 0;
  logic [15:0] mret = 0;

  ula_wb_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_resu(in_resu),
    .in_o(in_o), .in_c(in_c), .in_s(in_s), .in_z(in_z), .in_op(in_op), .in_we(in_we),
    .in_dest(in_dest), .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flag_o(flag_o), .flag_c(flag_c),
    .flag_s(flag_s), .flag_z(flag_z), .flags_pending(flags_pending), .cond_sel(cond_sel),
    .cond_true(cond_true), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [2:0] sel);
    case (sel)
      3'd0: return 1'b1;
      3'd1: return mf[0];
      3'd2: return !mf[0];
      3'd3: return mf[1];
      3'd4: return !mf[1];
      3'd5: return mf[2];
      3'd6: return mf[3];
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all();
    logic pend = 0;
    foreach (q[i]) if (q[i].upd) pend = 1;
    chk("rf_valid", rf_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("flags", {flag_o, flag_c, flag_s, flag_z}, mf);
    chk("pending", flags_pending, pend);
    chk("cond", cond_true, ref_cond(cond_sel));
    chk("retired", retired, mret);
    if (q.size() != 0) begin
      chk("waddr", rf_waddr, q[0].dest);
      chk("wdata", rf_wdata, q[0].resu);
      chk("we", rf_we, q[0].we);
    end
  endtask

  task automatic drive(input logic [15:0] r, input logic [3:0] f, input logic [7:0] op,
                       input logic we, input logic [3:0] d);
    in_resu = r;
    {in_o, in_c, in_s, in_z} = f;
    in_op = op;
    in_we = we;
    in_dest = d;
  endtask

  // one clock: model sees the pre-edge inputs, DUT is sampled 1 ns after the edge
  task automatic tick(input bit c);
    bit acc, ret;
    ent_t e;
    acc = in_valid && q.size() < 2;
    ret = rf_ready && q.size() != 0;
    e = '{resu: in_resu, o: in_o, c: in_c, s: in_s, z: in_z, we: in_we, dest: in_dest,
          upd: in_op[7:6] == 2'b10};
    @(posedge clk);
    #1;
    if (ret) begin
      if (q[0].upd) mf = {q[0].o, q[0].c, q[0].s, q[0].z};
      void'(q.pop_front());
      mret++;
    end
    if (acc) q.push_back(e);
    if (c) check_all();
  endtask

  initial begin
    #2;
    check_all();
    #10 rst = 0;
    // single arithmetic op
    drive(16'h8000, 4'b1010, 8'h80, 1, 4'd3);
    in_valid = 1; rf_ready = 1; cond_sel = 3'd3;
    tick(1);
    in_valid = 0;
    chk("single_waddr", rf_waddr, 4'd3);
    chk("single_wdata", rf_wdata, 16'h8000);
    chk("single_cond_before", cond_true, 1'b0);
    tick(1);
    chk("single_flag_s", flag_s, 1'b1);
    chk("single_flag_o", flag_o, 1'b1);
    chk("single_cond_after", cond_true, 1'b1);
    // set Z, then a constant-format op must leave it alone
    drive(16'h0000, 4'b0001, 8'h80, 1, 4'd1);
    in_valid = 1;
    tick(1);
    in_valid = 0;
    tick(1);
    chk("z_set", flag_z, 1'b1);
    drive(16'h0000, 4'b0000, 8'h40, 1, 4'd5);
    in_valid = 1; cond_sel = 3'd1;
    tick(1);
    in_valid = 0;
    chk("const_pending", flags_pending, 1'b0);
    chk("const_we", rf_we, 1'b1);
    tick(1);
    chk("const_flag_z", flag_z, 1'b1);
    chk("const_cond_z", cond_true, 1'b1);
    chk("const_pending_after", flags_pending, 1'b0);
    // backpressure, then full with simultaneous retire request
    rf_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      drive(16'h1000 + 16'(i), 4'(i + 4), 8'h80, 1, 4'(i + 8));
      tick(1);
    end
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head", rf_wdata, 16'h1000);
    rf_ready = 1;
    tick(1);
    chk("full_sim_head", rf_wdata, 16'h1001);
    chk("full_sim_ready", in_ready, 1'b1);
    tick(1);
    chk("both_head", rf_wdata, 16'h1002);
    chk("both_valid", rf_valid, 1'b1);
    chk("both_ready", in_ready, 1'b1);
    in_valid = 0;
    tick(1);
    chk("drain_valid", rf_valid, 1'b0);
    // asynchronous reset with a full FIFO
    rf_ready = 0; in_valid = 1;
    drive(16'hBEEF, 4'b1111, 8'h9A, 1, 4'd7);
    tick(1);
    tick(1);
    #2 rst = 1;
    #1;
    q.delete(); mf = 0; mret = 0;
    check_all();
    chk("rst_valid", rf_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_flags", {flag_o, flag_c, flag_s, flag_z}, 4'b0000);
    chk("rst_retired", retired, 16'h0000);
    in_valid = 0;
    #2 rst = 0;
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom % 4) != 0;
      rf_ready = ($urandom % 3) != 0;
      cond_sel = 3'($urandom);
      drive(16'($urandom), 4'($urandom), ($urandom % 2) ? {2'b10, 6'($urandom)} : 8'($urandom),
            1'($urandom), 4'($urandom));
      tick(1);
    end
    // run the retire counter up to its wrap point
    in_valid = 1; rf_ready = 1;
    drive(16'h1234, 4'b0000, 8'h01, 1, 4'd2);
    for (int n = 0; n < 70000 && mret != 16'hFFFF; n++) tick(0);
    check_all();
    chk("wrap_reach", retired, 16'hFFFF);
    drive(16'h5A5A, 4'b0110, 8'h88, 1, 4'd9);
    tick(1);
    chk("wrap_zero", retired, 16'h0000);
    chk("wrap_pending", flags_pending, 1'b1);
    in_valid = 0; rf_ready = 0;
    tick(1);
    chk("hold_pending", flags_pending, 1'b1);
    rf_ready = 1;
    tick(1);
    chk("clear_pending", flags_pending, 1'b0);
    chk("wrap_flags", {flag_o, flag_c, flag_s, flag_z}, 4'b0110);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
